// File: rtl/counter_cmd_sequencer_if.sv
// Command channel into the counter sequencer: one {op, len, dat} record per vld&rdy beat.
// The master drives the command and vld. The slave drives rdy.
interface counter_cmd_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic             cmd_vld;
    logic             cmd_rdy;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_len;
    logic [WIDTH-1:0] cmd_dat;

    modport master (
        output cmd_vld,
        output cmd_op,
        output cmd_len,
        output cmd_dat,
        input  cmd_rdy
    );

    modport slave (
        input  cmd_vld,
        input  cmd_op,
        input  cmd_len,
        input  cmd_dat,
        output cmd_rdy
    );
endinterface

// File: rtl/counter_cmd_sequencer.sv
// Sequencer that drives an up/down/load counter from a DEPTH-entry command FIFO.
// Timing: pop to first RUN is 1 cycle, and DONE comes 2 cycles after the last RUN. cmd_rdy is low while the FIFO is full.
module counter_cmd_sequencer_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [DW-1:0]          wdat_i,
    input  logic                   pop_i,
    output logic [DW-1:0]          rdat_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdat_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdat_i;
        end
    end
endmodule

module counter_cmd_sequencer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    counter_cmd_sequencer_if.slave cmd_if,
    input  logic [WIDTH-1:0]       q_i,
    input  logic                   rco_i,
    output logic [1:0]             modo_o,
    output logic                   enb_o,
    output logic [WIDTH-1:0]       d_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [CNT_W-1:0]       rco_cnt_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam logic [2:0] OP_UP    = 3'd0;
    localparam logic [2:0] OP_DOWN  = 3'd1;
    localparam logic [2:0] OP_DOWN3 = 3'd2;
    localparam logic [2:0] OP_LOAD  = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [1:0] MODO_UP    = 2'b00;
    localparam logic [1:0] MODO_DOWN  = 2'b01;
    localparam logic [1:0] MODO_DOWN3 = 2'b10;
    localparam logic [1:0] MODO_LOAD  = 2'b11;

    typedef struct packed {
        logic [2:0]       op;
        logic [CNT_W-1:0] len;
        logic [WIDTH-1:0] dat;
    } cmd_t;

    cmd_t             wr_cmd;
    cmd_t             head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    logic [1:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic             primed_q, primed_d;
    logic             run_q;
    logic             done_q;
    logic [CNT_W-1:0] rco_cnt_q, rco_cnt_d;
    logic             init_q;

    assign wr_cmd.op  = cmd_if.cmd_op;
    assign wr_cmd.len = cmd_if.cmd_len;
    assign wr_cmd.dat = cmd_if.cmd_dat;

    // Ready stays low through reset and rises on the first edge after release.
    assign cmd_if.cmd_rdy = init_q & ~fifo_full;
    assign push           = cmd_if.cmd_vld & cmd_if.cmd_rdy;

    counter_cmd_sequencer_fifo #(
        .DW    ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdat_i  (wr_cmd),
        .pop_i   (pop),
        .rdat_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        d_d      = d_q;
        remain_d = remain_q;
        primed_d = primed_q;
        pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    op_d     = head.op;
                    d_d      = head.dat;
                    primed_d = 1'b1;
                    if ((head.op inside {OP_UP, OP_DOWN, OP_DOWN3}) && (head.len != '0)) begin
                        state_d  = ST_RUN;
                        remain_d = head.len;
                    end else if (head.op inside {OP_LOAD, OP_CLEAR}) begin
                        state_d  = ST_RUN;
                        remain_d = CNT_W'(1);
                    end else begin
                        state_d  = ST_WAIT;
                        remain_d = '0;
                    end
                end
            end
            ST_RUN: begin
                remain_d = remain_q - CNT_W'(1);
                if (remain_q == CNT_W'(1)) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // RCO is one edge late, so it is qualified by the previous cycle having been RUN.
    always_comb begin
        rco_cnt_d = rco_cnt_q;
        if (pop) begin
            rco_cnt_d = '0;
        end else if (run_q && rco_i && (rco_cnt_q != '1)) begin
            rco_cnt_d = rco_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            d_q       <= '0;
            remain_q  <= '0;
            primed_q  <= 1'b0;
            run_q     <= 1'b0;
            done_q    <= 1'b0;
            rco_cnt_q <= '0;
            init_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            d_q       <= d_d;
            remain_q  <= remain_d;
            primed_q  <= primed_d;
            run_q     <= (state_q == ST_RUN);
            done_q    <= (state_q == ST_WAIT);
            rco_cnt_q <= rco_cnt_d;
            init_q    <= 1'b1;
        end
    end

    // Outside RUN, the counter is held by reloading its own Q, since ENB=0 would clear it.
    always_comb begin
        enb_o  = 1'b0;
        modo_o = MODO_LOAD;
        d_o    = '0;
        if (state_q == ST_RUN) begin
            case (op_q)
                OP_UP: begin
                    enb_o  = 1'b1;
                    modo_o = MODO_UP;
                end
                OP_DOWN: begin
                    enb_o  = 1'b1;
                    modo_o = MODO_DOWN;
                end
                OP_DOWN3: begin
                    enb_o  = 1'b1;
                    modo_o = MODO_DOWN3;
                end
                OP_LOAD: begin
                    enb_o  = 1'b1;
                    modo_o = MODO_LOAD;
                    d_o    = d_q;
                end
                default: enb_o = 1'b0;
            endcase
        end else if (primed_q) begin
            enb_o  = 1'b1;
            modo_o = MODO_LOAD;
            d_o    = q_i;
        end
    end

    assign busy_o    = (state_q != ST_IDLE) | ~fifo_empty;
    assign done_o    = done_q;
    assign rco_cnt_o = rco_cnt_q;
endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Bench for counter_cmd_sequencer on a 4-bit counter: directed command table plus FIFO-full and async-reset sequences.
module tb_counter_cmd_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] cq = 4'h0;
    logic       rco_c = 1'b0;
    logic [1:0] modo;
    logic       enb;
    logic [3:0] dd;
    logic       busy;
    logic       done;
    logic [7:0] rco_cnt;
    logic [2:0] level;

    int n_total = 0;
    int n_pass  = 0;

    counter_cmd_sequencer_if #(.WIDTH(4), .CNT_W(8)) cmd_if ();

    counter_cmd_sequencer #(.WIDTH(4), .DEPTH(4), .CNT_W(8)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .cmd_if    (cmd_if),
        .q_i       (cq),
        .rco_i     (rco_c),
        .modo_o    (modo),
        .enb_o     (enb),
        .d_o       (dd),
        .busy_o    (busy),
        .done_o    (done),
        .rco_cnt_o (rco_cnt),
        .level_o   (level)
    );

    always #5 clk = ~clk;

    // 4-bit counter cell: ENB=0 clears; registered RCO marks a wrap.
    always @(posedge clk) begin
        rco_c <= 1'b0;
        if (!enb) begin
            cq <= 4'h0;
        end else begin
            case (modo)
                2'b00: begin cq <= cq + 4'd1; rco_c <= (cq == 4'hF); end
                2'b01: begin cq <= cq - 4'd1; rco_c <= (cq == 4'h0); end
                2'b10: begin cq <= cq - 4'd3; rco_c <= (cq <= 4'd2); end
                default: cq <= dd;
            endcase
        end
    end

    typedef struct {
        logic [2:0] op;
        logic [7:0] len;
        logic [3:0] d;
        logic [1:0] exp_modo;
        logic [3:0] exp_q;
        logic [7:0] exp_rco;
        int         exp_cnt;
        int         exp_off;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: bound expired, got no event, expected one", name);
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [7:0] len, input logic [3:0] d);
        int w;
        w = 0;
        @(negedge clk);
        cmd_if.cmd_vld = 1'b1;
        cmd_if.cmd_op  = op;
        cmd_if.cmd_len = len;
        cmd_if.cmd_dat = d;
        while (!cmd_if.cmd_rdy && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) fail_now("push_rdy");
        @(posedge clk);
        #1 cmd_if.cmd_vld = 1'b0;
    endtask

    initial begin
        int cnt;
        int off;
        int w;
        int ndone;
        logic pd;
        logic [3:0] qlog[$];
        logic [3:0] exp_order[6];

        cmd_if.cmd_vld = 1'b0;
        cmd_if.cmd_op  = 3'd0;
        cmd_if.cmd_len = 8'd0;
        cmd_if.cmd_dat = 4'h0;

        //                op     len     d      modo   q      rco    cnt off
        vecs[0]  = '{3'd3, 8'd0,   4'hE, 2'b11, 4'hE, 8'd0,  0,   1};
        vecs[1]  = '{3'd0, 8'd3,   4'h0, 2'b00, 4'h1, 8'd1,  3,   0};
        vecs[2]  = '{3'd3, 8'd0,   4'h2, 2'b11, 4'h2, 8'd0,  0,   0};
        vecs[3]  = '{3'd2, 8'd2,   4'h0, 2'b10, 4'hC, 8'd1,  2,   0};
        vecs[4]  = '{3'd1, 8'd5,   4'h0, 2'b01, 4'h7, 8'd0,  5,   0};
        vecs[5]  = '{3'd1, 8'd8,   4'h0, 2'b01, 4'hF, 8'd1,  8,   0};
        vecs[6]  = '{3'd0, 8'd0,   4'h0, 2'b11, 4'hF, 8'd0,  0,   0};
        vecs[7]  = '{3'd4, 8'd7,   4'h5, 2'b11, 4'h0, 8'd0,  0,   1};
        vecs[8]  = '{3'd6, 8'd5,   4'h9, 2'b11, 4'h0, 8'd0,  0,   0};
        vecs[9]  = '{3'd3, 8'd0,   4'hF, 2'b11, 4'hF, 8'd0,  0,   0};
        vecs[10] = '{3'd0, 8'd255, 4'h0, 2'b00, 4'hE, 8'd16, 255, 0};
        vecs[11] = '{3'd0, 8'd255, 4'h0, 2'b00, 4'hD, 8'd16, 255, 0};

        exp_order[0] = 4'h1; exp_order[1] = 4'h3; exp_order[2] = 4'h5;
        exp_order[3] = 4'h9; exp_order[4] = 4'h8; exp_order[5] = 4'h9;

        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_enb", int'(enb), 0);
        chk("rst_modo", int'(modo), 3);
        chk("rst_d", int'(dd), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rco_cnt", int'(rco_cnt), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rdy", int'(cmd_if.cmd_rdy), 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rdy_at_release", int'(cmd_if.cmd_rdy), 0);
        @(negedge clk);
        chk("rdy_after_release", int'(cmd_if.cmd_rdy), 1);

        for (int i = 0; i < 12; i++) begin
            push_cmd(vecs[i].op, vecs[i].len, vecs[i].d);
            cnt = 0;
            off = 0;
            w   = 0;
            while (w < 700) begin
                @(negedge clk);
                w++;
                if (!enb) off++;
                else if (modo != 2'b11 && modo == vecs[i].exp_modo) cnt++;
                if (done) break;
            end
            if (!done) fail_now($sformatf("v%0d_done", i));
            chk($sformatf("v%0d_rco_cnt", i), int'(rco_cnt), int'(vecs[i].exp_rco));
            chk($sformatf("v%0d_q", i), int'(cq), int'(vecs[i].exp_q));
            chk($sformatf("v%0d_run_cycles", i), cnt, vecs[i].exp_cnt);
            chk($sformatf("v%0d_enb_low_cycles", i), off, vecs[i].exp_off);
        end

        // FIFO fill while a long command runs; the fifth push waits for the first pop.
        push_cmd(3'd0, 8'd20, 4'h0);
        @(negedge clk);
        @(negedge clk);
        chk("full_start_level", int'(level), 0);
        chk("full_start_busy", int'(busy), 1);
        ndone = 0;
        fork
            begin
                for (int c = 0; c < 300 && ndone < 6; c++) begin
                    @(negedge clk);
                    if (done) begin
                        ndone++;
                        qlog.push_back(cq);
                    end
                end
            end
            begin
                push_cmd(3'd3, 8'd0, 4'h3);
                push_cmd(3'd0, 8'd2, 4'h0);
                push_cmd(3'd3, 8'd0, 4'h9);
                push_cmd(3'd1, 8'd1, 4'h0);
                @(negedge clk);
                chk("full_level", int'(level), 4);
                chk("full_rdy", int'(cmd_if.cmd_rdy), 0);
                cmd_if.cmd_vld = 1'b1;
                cmd_if.cmd_op  = 3'd0;
                cmd_if.cmd_len = 8'd1;
                cmd_if.cmd_dat = 4'h0;
                pd = 1'b0;
                w  = 0;
                while (!cmd_if.cmd_rdy && w < 200) begin
                    pd = done;
                    @(negedge clk);
                    w++;
                end
                if (w >= 200) fail_now("full_rdy_rise");
                else chk("rdy_rise_after_pop", int'(pd), 1);
                @(posedge clk);
                #1 cmd_if.cmd_vld = 1'b0;
            end
        join
        chk("order_done_count", ndone, 6);
        for (int k = 0; k < 6; k++) begin
            if (k < qlog.size()) chk($sformatf("order_q%0d", k), int'(qlog[k]), int'(exp_order[k]));
            else fail_now($sformatf("order_q%0d", k));
        end

        // Asynchronous reset in the middle of UP len=10 with a command still queued.
        push_cmd(3'd0, 8'd10, 4'h0);
        push_cmd(3'd3, 8'd0, 4'h5);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_level", int'(level), 1);
        chk("pre_rst_enb", int'(enb), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_enb", int'(enb), 0);
        chk("midrst_level", int'(level), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (c == 0) chk("midrst_rdy_after", int'(cmd_if.cmd_rdy), 1);
            if (done) ndone++;
        end
        chk("midrst_no_done", ndone, 0);
        chk("midrst_q_cleared", int'(cq), 0);
        chk("midrst_idle", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/counter_cmd_sequencer.md
Name: counter_cmd_sequencer

Overview:
Command-driven controller for the synchronous up/down/load counter datapath (4-bit cell or 16-bit cascade).
- Requesters push counting commands (operation, load value, cycle count) through a valid/ready port into a small FIFO.
- The sequencer executes commands one at a time by driving the counter's MODO/ENB/D inputs.
- It counts RCO events per command and pulses DONE on completion.
- Between commands it holds the counter value by reloading Q, because ENB=0 clears the counter.

Parameters:
WIDTH, 16, counter data width (D/Q).
DEPTH, 4, command FIFO entries; power of 2, >=2.
CNT_W, 8, width of CMD_LEN and RCO_CNT.

Ports:
CLK  input  1  single clock; all state updates on posedge.
RESET  input  1  asynchronous, active-high reset.
CMD_VALID  input  1  command offered.
CMD_READY  output  1  FIFO can accept; equals !full.
CMD_OP  input  3  0=UP, 1=DOWN, 2=DOWN3, 3=LOAD, 4=CLEAR, 5-7=no-op.
CMD_LEN  input  CNT_W  enabled cycles for UP/DOWN/DOWN3; ignored otherwise.
CMD_D  input  WIDTH  load value for LOAD.
Q_IN  input  WIDTH  counter Q feedback.
RCO  input  1  counter RCO feedback.
MODO  output  2  to counter MODO.
ENB  output  1  to counter ENB.
D  output  WIDTH  to counter D.
BUSY  output  1  state!=IDLE or FIFO non-empty.
DONE  output  1  one-cycle completion pulse.
RCO_CNT  output  CNT_W  RCO events of the last/current command, saturating.
LEVEL  output  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
Reset (async, while RESET=1):
- FIFO emptied; state=IDLE; primed=0; active registers=0.
- Outputs: ENB=0, MODO=11, D=0, DONE=0, RCO_CNT=0, LEVEL=0, BUSY=0, CMD_READY=0.
- CMD_READY=1 from the first cycle after RESET deasserts.
- Reset mid-command aborts it: no DONE. The counter clears on following edges because ENB=0.

FIFO:
- Push when CMD_VALID & CMD_READY; {op, len, d} stored in order.
- Pop only in IDLE when LEVEL!=0. No bypass: a push into an empty FIFO is popped at the earliest in the next cycle.
- Push and pop in the same cycle: LEVEL unchanged.
- Full: CMD_READY=0; the pushed entry is ignored.

FSM (states IDLE, RUN, WAIT):
- IDLE, FIFO non-empty: pop into active op/len/d; RCO_CNT<=0; primed<=1.
  - UP/DOWN/DOWN3 with len>0 -> RUN with remain=len.
  - LOAD/CLEAR -> RUN with remain=1.
  - len=0 or no-op -> WAIT.
- RUN: each cycle drives the op and decrements remain. When remain==1 -> WAIT. RUN lasts exactly remain cycles.
- WAIT: one cycle, then IDLE. Covers counter RCO latency.

Datapath output decode (combinational from state/active regs):
- RUN UP: ENB=1, MODO=00.
- RUN DOWN: ENB=1, MODO=01.
- RUN DOWN3: ENB=1, MODO=10.
- RUN LOAD: ENB=1, MODO=11, D=active d.
- RUN CLEAR: ENB=0.
- IDLE/WAIT with primed=1 (hold): ENB=1, MODO=11, D=Q_IN.
- IDLE with primed=0: ENB=0, MODO=11, D=0.
- D=0 whenever it is not specified above.

RCO counting:
- run_d = registered (state==RUN).
- When run_d & RCO, RCO_CNT increments, saturating at 2^CNT_W-1.
- This captures the RCO produced by the final RUN edge during WAIT.

DONE:
- Registered; asserted in the first IDLE cycle after WAIT.
- RCO_CNT is final and valid in the DONE cycle.
- A pop in the DONE cycle clears RCO_CNT at the next edge.

Back-to-back: from command N's last RUN cycle k, DONE appears in k+2. Command N+1 RUN starts at k+3 at the earliest.

Test Plan:
1. WIDTH=4 with the 4-bit counter. RESET pulse, then push LOAD d=0xE and UP len=3.
   - Required: Q goes E,F,0,1.
   - ENB=1 and MODO=00 for exactly 3 cycles.
   - DONE twice; RCO_CNT=1 at the second DONE.
   - Q stays 1 in hold afterwards.
2. LOAD d=0x2, then DOWN3 len=2.
   - Required: Q goes 2 -> F -> C.
   - RCO_CNT=1, from Q=2 <= 2.
3. With LEVEL=0, push 5 commands back-to-back with CMD_VALID held.
   - Required: CMD_READY drops after 4 pushes (LEVEL=4).
   - Re-rises the cycle after the first pop; order preserved.
4. UP len=0, CLEAR, and op=6.
   - Required: each yields DONE with RCO_CNT=0.
   - CLEAR drives ENB=0 for one cycle and Q=0.
   - len=0 and op=6 produce no ENB/MODO change from hold.
5. Assert RESET asynchronously in the middle of UP len=10.
   - Required: immediately ENB=0, LEVEL=0, BUSY=0.
   - No DONE; CMD_READY=1 one cycle after release.
6. 4-bit counter at Q=0xF, UP len=255 followed by UP len=255.
   - Required: RCO_CNT counts one event per wrap, 16 per command.
   - The second command's count starts from 0.
